// File: rtl/ser_pkg.sv
// ser_pkg: shared types and helpers for the bit-stream serializer.
//   ser_state_t    - serializer FSM states (PARITY only reached when
//                    SER_PARITY_EN is defined)
//   SER_WIDTH_DEF  - default word width
//   ser_cnt_width  - width of the bit counter for a given word width
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH_DEF = 20;

  // The counter has to hold WIDTH+1 (the parity bit position) without
  // wrapping, so size it for WIDTH+2 distinct values.
  function automatic int ser_cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/ser_parity_acc.sv
// ser_parity_acc: running-XOR (even parity) accumulator.
// Ports:
//   clk       in  rising-edge clock
//   rst       in  synchronous active-high reset (clears the accumulator)
//   clr_i     in  start a new word; accumulator loads clr_bit_i
//   clr_bit_i in  first bit of the new word
//   upd_i     in  fold bit_i into the running parity
//   bit_i     in  bit being presented this step
//   parity_o  out XOR of all bits folded in since the last clear
module ser_parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic clr_bit_i,
  input  logic upd_i,
  input  logic bit_i,
  output logic parity_o
);

  logic par_q;
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (clr_i) begin
      par_d = clr_bit_i;
    end else if (upd_i) begin
      par_d = par_q ^ bit_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_o = par_q;

endmodule

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel-to-serial stage feeding a serial
// sequence detector. A WIDTH-bit word is accepted over valid/ready and
// presented LSB-first, one bit per clock, with a qualifying strobe, a
// frame-last marker and a one-cycle done pulse after each frame.
// Back-to-back words stream with no idle bits in between.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// (XOR of the accepted word) after data bit WIDTH-1.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   load_valid  in   upstream offers load_data
//   load_data   in   WIDTH-bit word, bit 0 sent first
//   load_ready  out  block accepts a word this cycle (combinational)
//   x           out  serial bit (registered), IDLE_BIT when idle
//   x_valid     out  x carries a frame bit (registered)
//   last        out  x is the final bit of the frame (registered)
//   done        out  one-cycle pulse after a frame's final bit (registered)
//
// Handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on state, counter and
// rst, never on load_valid; it is high when idle or while the final bit of
// the current frame is on x, so the next word follows with no gap.
// Upstream must hold load_valid/load_data until the transfer happens.
module bit_stream_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH    = SER_WIDTH_DEF,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             done
);

  localparam int             CW       = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH);
  localparam logic [CW-1:0]  ONE_CNT  = CW'(1);
`ifdef SER_PARITY_EN
  localparam logic ONE_BIT_FRAME = 1'b0;
`else
  localparam logic ONE_BIT_FRAME = (WIDTH == 1);
`endif

  ser_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;        // bits presented so far, incl. x
  logic [WIDTH-1:0] sreg_q, sreg_d;      // bits still to present, LSB next
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic             final_bit;           // final frame bit is on x now
  logic             accept;

`ifdef SER_PARITY_EN
  logic parity_bit;
  logic par_upd;

  // Fold in every data bit as it moves onto x; the accept bit is loaded
  // through the clear path.
  assign par_upd = (state_q == SHIFT) && (cnt_q < LAST_CNT);

  ser_parity_acc u_parity_acc (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept),
    .clr_bit_i (load_data[0]),
    .upd_i     (par_upd),
    .bit_i     (sreg_q[0]),
    .parity_o  (parity_bit)
  );

  assign final_bit = (state_q == PARITY);
`else
  assign final_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif

  assign load_ready = !rst && ((state_q == IDLE) || final_bit);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    last_d    = last_q;
    done_d    = 1'b0;

    case (state_q)
      SHIFT: begin
        if (cnt_q < LAST_CNT) begin
          x_d    = sreg_q[0];
          sreg_d = sreg_q >> 1;
          cnt_d  = cnt_q + 1'b1;
`ifdef SER_PARITY_EN
          last_d = 1'b0;
`else
          last_d = ((cnt_q + 1'b1) == LAST_CNT);
`endif
        end
`ifdef SER_PARITY_EN
        else begin
          state_d = PARITY;
          x_d     = parity_bit;
          cnt_d   = cnt_q + 1'b1;
          last_d  = 1'b1;
        end
`endif
      end
      default: ;
    endcase

    // End of frame: go idle and pulse done.
    if (final_bit) begin
      state_d   = IDLE;
      cnt_d     = '0;
      x_d       = IDLE_BIT;
      x_valid_d = 1'b0;
      last_d    = 1'b0;
      done_d    = 1'b1;
    end

    // A new word overrides the idle return; done still pulses when this
    // accept coincides with the previous frame's final bit.
    if (accept) begin
      state_d   = SHIFT;
      cnt_d     = ONE_CNT;
      sreg_d    = load_data >> 1;
      x_d       = load_data[0];
      x_valid_d = 1'b1;
      last_d    = ONE_BIT_FRAME;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      x_q       <= IDLE_BIT;
      x_valid_q <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign last    = last_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench for bit_stream_serializer. A frame-level model
// (queue of pending frame bits) predicts x/x_valid/last/done/load_ready
// every cycle; a scoreboard rebuilds each received frame and matches it
// against the words the model saw accepted; directed scenarios pin the
// model with hand-computed literals.
module tb_bit_stream_serializer;

  localparam int W = 20;
`ifdef SER_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif
  localparam logic IDLE_V = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         x;
  logic         x_valid;
  logic         last;
  logic         done;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  bit_stream_serializer #(
    .WIDTH    (W),
    .IDLE_BIT (IDLE_V)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .x          (x),
    .x_valid    (x_valid),
    .last       (last),
    .done       (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame view: on accept, the whole frame is queued as bits; each cycle
  // the next bit moves to x. The frame ends when the queue is exhausted.
  logic         m_x    = IDLE_V;
  logic         m_v    = 1'b0;
  logic         m_last = 1'b0;
  logic         m_done = 1'b0;
  logic         bit_q[$];
  logic [W-1:0] exp_q[$];
  bit           started = 1'b0;

  always @(posedge clk) begin
    logic was_final;
    logic m_rdy;
    m_rdy     = !rst && (!m_v || m_last);
    was_final = m_v && m_last;
    started   = 1'b1;
    if (rst) begin
      m_x = IDLE_V; m_v = 1'b0; m_last = 1'b0; m_done = 1'b0;
      bit_q.delete();
      exp_q.delete();
    end else if (load_valid && m_rdy) begin
      bit_q.delete();
      for (int i = 0; i < W; i++) bit_q.push_back(load_data[i]);
`ifdef SER_PARITY_EN
      bit_q.push_back(^load_data);
`endif
      exp_q.push_back(load_data);
      m_x    = bit_q.pop_front();
      m_v    = 1'b1;
      m_last = (bit_q.size() == 0);
      m_done = was_final;
    end else if (was_final) begin
      m_x = IDLE_V; m_v = 1'b0; m_last = 1'b0; m_done = 1'b1;
    end else if (m_v) begin
      m_x    = bit_q.pop_front();
      m_last = (bit_q.size() == 0);
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  end

  // ---------------- compare + scoreboard ----------------
  int           rx_idx   = 0;
  logic [W-1:0] rx_word  = '0;
  int           run      = 0;
  int           max_run  = 0;
  int           done_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("x", x, m_x);
      chk("x_valid", x_valid, m_v);
      chk("last", last, m_last);
      chk("done", done, m_done);
      chk("load_ready", load_ready, !rst && (!m_v || m_last));

      if (x_valid) begin
        if (rx_idx < W) rx_word[rx_idx] = x;
        rx_idx++;
        if (last) begin
          chk("sb_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) chk("sb_word", rx_word, exp_q.pop_front());
          rx_idx = 0;
        end
      end else begin
        rx_idx = 0;
      end

      if (x_valid) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until the edge that transfers it; returns
  // just after that edge, with bit 0 on x.
  task automatic send_word(input logic [W-1:0] d);
    logic r;
    int   n;
    load_valid = 1'b1;
    load_data  = d;
    r = 1'b0;
    n = 0;
    while (!r && n < 100) begin
      @(negedge clk);
      r = load_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accepted", r, 1'b1);
  endtask

  // Sample the FB frame bits starting at the next negedge.
  task automatic capture_frame(output logic [W:0] cap, output int nlast, output int lidx);
    cap   = '0;
    nlast = 0;
    lidx  = -1;
    for (int i = 0; i < FB; i++) begin
      @(negedge clk);
      cap[i] = x;
      if (last) begin
        nlast++;
        lidx = i;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W:0] cap;
  int         nl;
  int         li;

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;

    // Reset and idle
    repeat (2) step();
    chk("t1_rst_ready", load_ready, 1'b0);
    chk("t1_rst_xv", x_valid, 1'b0);
    chk("t1_rst_x", x, 1'b0);
    rst = 1'b0;
    #1;
    chk("t1_ready_after", load_ready, 1'b1);
    repeat (3) step();
    chk("t1_idle_xv", x_valid, 1'b0);
    chk("t1_idle_last", last, 1'b0);
    chk("t1_idle_done", done, 1'b0);
    chk("t1_idle_x", x, 1'b0);

    // Single frame 20'h9084C
    send_word(20'h9084C);
    load_valid = 1'b0;
    capture_frame(cap, nl, li);
    chk("t2_bits", cap[W-1:0], 20'h9084C);
    chk("t2_last_count", nl, 1);
    chk("t2_last_pos", li, FB - 1);
`ifdef SER_PARITY_EN
    chk("t6_parity_9084c", cap[W], 1'b0);
`endif
    step();
    chk("t2_done", done, 1'b1);
    chk("t2_done_xv", x_valid, 1'b0);
    step();
    chk("t2_done_once", done, 1'b0);

    // Back-to-back frames
    max_run  = 0;
    done_cnt = 0;
    send_word(20'h9084C);
    send_word(20'h00001);
    load_valid = 1'b0;
    repeat (FB + 4) step();
    chk("t3_contiguous", max_run, 2 * FB);
    chk("t3_done_count", done_cnt, 2);

    // Single frame 20'h00001 (pins the second pattern and its parity)
    send_word(20'h00001);
    load_valid = 1'b0;
    capture_frame(cap, nl, li);
    chk("t3_bits_one", cap[W-1:0], 20'h00001);
`ifdef SER_PARITY_EN
    chk("t6_parity_00001", cap[W], 1'b1);
`endif
    repeat (2) step();

    // Reset mid-frame
    done_cnt = 0;
    send_word(20'hFFFFF);
    load_valid = 1'b0;
    repeat (7) step();
    chk("t4_bit7_xv", x_valid, 1'b1);
    chk("t4_bit7_x", x, 1'b1);
    rst = 1'b1;
    step();
    chk("t4_xv_drop", x_valid, 1'b0);
    chk("t4_no_done", done, 1'b0);
    chk("t4_ready_in_rst", load_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("t4_ready_after", load_ready, 1'b1);
    repeat (3) step();
    chk("t4_done_cnt", done_cnt, 0);
    send_word(20'h9084C);
    load_valid = 1'b0;
    capture_frame(cap, nl, li);
    chk("t4_restart_bits", cap[W-1:0], 20'h9084C);
    repeat (2) step();

    // load_valid mid-frame is ignored
    send_word(20'h12345);
    load_valid = 1'b0;
    fork
      capture_frame(cap, nl, li);
      begin
        repeat (5) step();
        load_valid = 1'b1;
        load_data  = 20'hABCDE;
        repeat (3) step();
        load_valid = 1'b0;
      end
    join
    chk("t5_bits", cap[W-1:0], 20'h12345);
    chk("t5_last_pos", li, FB - 1);
    repeat (3) step();

    // Randomized traffic with occasional resets
    repeat (300) begin
      rst        = ($urandom_range(0, 49) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = W'($urandom);
      step();
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    repeat (FB + 3) step();
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_stream_serializer.md
# bit_stream_serializer

Parallel-to-serial stage that feeds the serial input `x` of the Mealy sequence detector. It accepts a WIDTH-bit word over a valid/ready handshake and presents it LSB-first, one bit per `clk` cycle, with a qualifying strobe and a frame-last marker. Back-to-back words stream without idle bits, so the detector sees a continuous bit stream.

## Interface
- `WIDTH`, 20: bits per word, legal range 1..64.
- `IDLE_BIT`, 1'b0: value driven on `x` when no frame bit is being presented.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  upstream offers `load_data`.
- `load_data`  in  WIDTH  word to serialize; bit 0 is sent first.
- `load_ready`  out  1  block accepts a word this cycle.
- `x`  out  1  serial bit to the detector; registered.
- `x_valid`  out  1  `x` carries a frame bit; registered.
- `last`  out  1  `x` is the final bit of the frame; registered.
- `done`  out  1  one-cycle pulse after a frame's final bit; registered.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- Accept = `load_valid && load_ready`.
- `load_ready` = !`rst` && (state==IDLE || final bit currently on `x`). Combinational from state, counter and `rst` only; it never depends on `load_valid`.
- On accept: `x`<=`load_data[0]`, `x_valid`<=1, shift reg<=`load_data`>>1, bit count<=1, `last`<=(WIDTH==1 and no parity), state<=SHIFT.
- SHIFT, bit count < WIDTH: `x`<=sreg[0], shift right, count+1. `last` is set when the count reaches WIDTH-1 (parity disabled).
- Final bit on `x` with an accept in the same cycle: the new word's bit 0 follows with no gap. `done` pulses while the new bit 0 is on `x`.
- Final bit on `x` with no accept: state<=IDLE, `x`<=IDLE_BIT, `x_valid`<=0, `last`<=0, `done`<=1 for one cycle.
- `load_valid` while busy and not on the final bit: ignored. Upstream holds the word.
- The bit counter is $clog2(WIDTH+2) wide and never wraps within a frame.

## Timing
- Reset values: `x`=IDLE_BIT, `x_valid`=0, `last`=0, `done`=0, state=IDLE. `load_ready`=0 while `rst` is high and 1 in the first cycle after.
- Latency: accept at edge k puts bit 0 on `x` from edge k until edge k+1. Bit i is on `x` in the cycle after edge k+i.
- Frame occupies WIDTH cycles, or WIDTH+1 with parity. Sustained throughput is 1 bit/cycle.
- `rst` mid-frame: the frame is abandoned at that edge, no `done` pulse, and outputs take reset values.
- `rst` and `load_valid` in the same cycle: reset wins and the word is not accepted.

## Configuration
- `SER_PARITY_EN` defined: after bit WIDTH-1, the block presents one extra bit equal to the even parity (XOR) of the accepted word, in state PARITY. `last` marks the parity bit. `load_ready` and back-to-back acceptance move to the parity cycle.
- `SER_PARITY_EN` undefined: no PARITY state. Frame is exactly WIDTH bits and `last` marks data bit WIDTH-1.

## Structure
- Package `ser_pkg`:
  - State enum `ser_state_t` {IDLE, SHIFT, PARITY}.
  - Default-width constant `SER_WIDTH_DEF`=20.
  - Counter-width helper function.
- Sub-module `ser_parity_acc`: a running-XOR parity accumulator. It is instantiated only under `SER_PARITY_EN`, cleared on accept and updated per shifted bit.
- All other logic lives in one module.

## Test plan
1. Reset for 2 cycles, then idle 3 cycles: `x`=0, `x_valid`=0, `last`=0, `done`=0 throughout. `load_ready`=0 during reset and 1 after.
2. Load 20'h9084C once. `x` must present 0,0,1,1,0,0,1,0,0,0,0,1,0,0,0,0,1,0,0,1 on 20 consecutive cycles with `x_valid`=1. `last`=1 on the 20th bit only, and `done`=1 on the following cycle.
3. Hold `load_valid` high with 20'h9084C then 20'h00001, offering the second word during the first word's final bit. Expect 40 contiguous `x_valid` cycles, the second frame being 1 followed by 19 zeros, and exactly one `done` pulse between the frames.
4. Assert `rst` for 1 cycle after bit 7 of 20'hFFFFF. `x_valid` must drop at that edge, with no `done` pulse and `load_ready`=1 on the next cycle. A new load then restarts from bit 0.
5. Assert `load_valid` mid-frame with a different word. The word must not be accepted, and the current frame completes unchanged.
6. With `SER_PARITY_EN` defined: 20'h9084C yields 21 bits ending in parity 0, and 20'h00001 yields parity 1. `last` is set on the parity bit.
